// File: rtl/hdmi_rx_fmt_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_rx_fmt_pkg
// Shared definitions for the HDMI RX format monitor:
//   - monitor state encoding (matches the o_state port values)
//   - format codes and the {width,height} table used for classification
//   - frame-rate saturation helper
// -----------------------------------------------------------------------------
package hdmi_rx_fmt_pkg;

   typedef enum logic [1:0] {
      ST_NO_SIGNAL = 2'd0,
      ST_ACQUIRE   = 2'd1,
      ST_LOCKED    = 2'd2,
      ST_HOLD      = 2'd3
   } mon_state_e;

   localparam logic [3:0] FMT_UNKNOWN = 4'd0;
   localparam logic [3:0] FMT_640X480 = 4'd1;
   localparam logic [3:0] FMT_720X480 = 4'd2;
   localparam logic [3:0] FMT_720P    = 4'd3;
   localparam logic [3:0] FMT_1080P   = 4'd4;
   localparam logic [3:0] FMT_2160P   = 4'd5;

   // Table index equals the format code reported for that entry.
   localparam int          FMT_ENTRIES = 5;
   localparam logic [13:0] FMT_W [1:5] = '{14'd640, 14'd720, 14'd1280, 14'd1920, 14'd3840};
   localparam logic [11:0] FMT_H [1:5] = '{12'd480, 12'd480, 12'd720,  12'd1080, 12'd2160};

   localparam int          FPS_W   = 8;
   localparam logic [31:0] FPS_MAX = 32'd255;

   // Saturate a 32-bit frame count to the reported fps width.
   function automatic logic [FPS_W-1:0] sat_fps(input logic [31:0] cnt);
      logic [FPS_W-1:0] r;
      if (cnt > FPS_MAX) begin
         r = 8'hFF;
      end else begin
         r = cnt[FPS_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/hdmi_rx_fmt_classify.sv
// -----------------------------------------------------------------------------
// hdmi_rx_fmt_classify
// Combinational lookup of a measured {width,height} against the known format
// table. Unlisted resolutions map to FMT_UNKNOWN.
// Ports:
//   width_i    [13:0]  width in pixels
//   height_i   [11:0]  height in lines
//   fmt_code_o [3:0]   format code (0 = unknown)
// -----------------------------------------------------------------------------
module hdmi_rx_fmt_classify
   import hdmi_rx_fmt_pkg::*;
(
   input  logic [13:0] width_i,
   input  logic [11:0] height_i,
   output logic [3:0]  fmt_code_o
);

   // Exact-match table scan; entries are unique so at most one hits.
   always_comb begin
      fmt_code_o = FMT_UNKNOWN;
      for (int i = 1; i <= FMT_ENTRIES; i++) begin
         fmt_code_o = ((width_i == FMT_W[i]) && (height_i == FMT_H[i])) ? 4'(i) : fmt_code_o;
      end
   end

endmodule

// File: rtl/hdmi_rx_format_monitor.sv
// -----------------------------------------------------------------------------
// hdmi_rx_format_monitor
// Samples the stream measurement stage once per frame (a fixed delay after
// each start-of-frame), debounces the {width,height} sample and reports a
// locked video format with its classified code.
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   s_axis_tvalid/tuser    tapped stream valid / start-of-frame
//   i_col_cnt [12:0]       beats per line
//   i_row_cnt [11:0]       lines per frame
//   i_frame_cnt [31:0]     frames in last second
//   o_state [1:0]          NO_SIGNAL / ACQUIRE / LOCKED / HOLD
//   o_locked               LOCKED or HOLD
//   o_width/o_height       locked resolution (0 when not locked)
//   o_fmt_code [3:0]       classified format (0 when not locked / unknown)
//   o_fps [7:0]            saturated frame count, updated at every capture
//   o_fmt_change           one-cycle pulse on lock gained or lost
// -----------------------------------------------------------------------------
module hdmi_rx_format_monitor
   import hdmi_rx_fmt_pkg::*;
#(
   parameter int unsigned C_PPC            = 2,
   parameter int          C_COL_OFFSET     = 0,
   parameter int unsigned C_SAMPLE_DELAY   = 4,
   parameter int unsigned C_LOCK_FRAMES    = 8,
   parameter int unsigned C_UNLOCK_FRAMES  = 3,
   parameter int unsigned C_TIMEOUT_CYCLES = 30000000
)
(
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tuser,
   input  logic [12:0] i_col_cnt,
   input  logic [11:0] i_row_cnt,
   input  logic [31:0] i_frame_cnt,
   output logic [1:0]  o_state,
   output logic        o_locked,
   output logic [13:0] o_width,
   output logic [11:0] o_height,
   output logic [3:0]  o_fmt_code,
   output logic [7:0]  o_fps,
   output logic        o_fmt_change
);

   localparam logic [31:0] TMO_LAST = 32'(C_TIMEOUT_CYCLES - 1);

   logic              sof_prev_q, sof_q;
   logic [3:0]        dly_cnt_q;
   logic [31:0]       tmo_cnt_q;
   mon_state_e        state_q;
   logic [13:0]       cand_w_q, width_q;
   logic [11:0]       cand_h_q, height_q;
   logic [7:0]        stable_cnt_q, miss_cnt_q;
   logic [3:0]        fmt_q;
   logic [7:0]        fps_q;
   logic              locked_q, chg_q;

   logic              sof_in_s, cap_s, tmo_s, valid_s, match_s, hit_s, unlock_s;
   logic signed [31:0] beats_s;
   logic [31:0]       w_full_s;
   logic [13:0]       samp_w_s;
   logic [11:0]       samp_h_s;
   logic [3:0]        samp_fmt_s;

   // Sample arithmetic, capture/timeout strobes and unlock decision.
   always_comb begin
      sof_in_s = s_axis_tuser & s_axis_tvalid;
      beats_s  = $signed({19'd0, i_col_cnt}) + 32'(C_COL_OFFSET);
      // A negative corrected beat count is treated as no picture.
      if (beats_s < 32'sd0) begin
         w_full_s = 32'd0;
      end else begin
         w_full_s = $unsigned(beats_s) * 32'(C_PPC);
      end
      if (w_full_s > 32'd16383) begin
         samp_w_s = 14'h3FFF;
      end else begin
         samp_w_s = w_full_s[13:0];
      end
      samp_h_s = i_row_cnt;
      valid_s  = (samp_w_s != 14'd0) && (samp_h_s != 12'd0);
      match_s  = (samp_w_s == cand_w_q) && (samp_h_s == cand_h_q);
      hit_s    = valid_s && match_s;
      cap_s    = (dly_cnt_q == 4'd1);
      tmo_s    = (tmo_cnt_q == TMO_LAST);
      // Unlock completes on the C_UNLOCK_FRAMES-th consecutive miss, which
      // for C_UNLOCK_FRAMES == 1 is the first miss seen while LOCKED.
      if (cap_s && !tmo_s && !hit_s) begin
         unlock_s = ((state_q == ST_LOCKED) && (C_UNLOCK_FRAMES == 1)) ||
                    ((state_q == ST_HOLD) && ((miss_cnt_q + 8'd1) == 8'(C_UNLOCK_FRAMES)));
      end else begin
         unlock_s = 1'b0;
      end
   end

   hdmi_rx_fmt_classify u_classify (
      .width_i    (samp_w_s),
      .height_i   (samp_h_s),
      .fmt_code_o (samp_fmt_s)
   );

   // SOF edge detect, capture delay (restarted by each SOF) and no-SOF timeout.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         sof_prev_q <= 1'b0;
         sof_q      <= 1'b0;
         dly_cnt_q  <= 4'd0;
         tmo_cnt_q  <= 32'd0;
      end else begin
         sof_prev_q <= sof_in_s;
         sof_q      <= sof_in_s & ~sof_prev_q;
         if (sof_q) begin
            dly_cnt_q <= 4'(C_SAMPLE_DELAY);
         end else if (dly_cnt_q != 4'd0) begin
            dly_cnt_q <= dly_cnt_q - 4'd1;
         end
         if (sof_q) begin
            tmo_cnt_q <= 32'd0;
         end else if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
         end
      end
   end

   // Lock state machine with registered status outputs.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= ST_NO_SIGNAL;
         cand_w_q     <= 14'd0;
         cand_h_q     <= 12'd0;
         stable_cnt_q <= 8'd0;
         miss_cnt_q   <= 8'd0;
         width_q      <= 14'd0;
         height_q     <= 12'd0;
         fmt_q        <= 4'd0;
         fps_q        <= 8'd0;
         locked_q     <= 1'b0;
         chg_q        <= 1'b0;
      end else begin
         chg_q <= 1'b0;
         if (tmo_s) begin
            chg_q        <= (state_q == ST_LOCKED) || (state_q == ST_HOLD);
            state_q      <= ST_NO_SIGNAL;
            cand_w_q     <= 14'd0;
            cand_h_q     <= 12'd0;
            stable_cnt_q <= 8'd0;
            miss_cnt_q   <= 8'd0;
            width_q      <= 14'd0;
            height_q     <= 12'd0;
            fmt_q        <= 4'd0;
            locked_q     <= 1'b0;
         end else if (cap_s) begin
            fps_q <= sat_fps(i_frame_cnt);
            if (unlock_s) begin
               chg_q        <= 1'b1;
               state_q      <= ST_ACQUIRE;
               cand_w_q     <= samp_w_s;
               cand_h_q     <= samp_h_s;
               stable_cnt_q <= {7'd0, valid_s};
               miss_cnt_q   <= 8'd0;
               width_q      <= 14'd0;
               height_q     <= 12'd0;
               fmt_q        <= 4'd0;
               locked_q     <= 1'b0;
            end else begin
               case (state_q)
                  ST_NO_SIGNAL: begin
                     if (valid_s) begin
                        state_q      <= ST_ACQUIRE;
                        cand_w_q     <= samp_w_s;
                        cand_h_q     <= samp_h_s;
                        stable_cnt_q <= 8'd1;
                     end
                  end
                  ST_ACQUIRE: begin
                     if (!valid_s) begin
                        cand_w_q     <= samp_w_s;
                        cand_h_q     <= samp_h_s;
                        stable_cnt_q <= 8'd0;
                     end else if (match_s) begin
                        if ((stable_cnt_q + 8'd1) == 8'(C_LOCK_FRAMES)) begin
                           state_q    <= ST_LOCKED;
                           locked_q   <= 1'b1;
                           width_q    <= samp_w_s;
                           height_q   <= samp_h_s;
                           fmt_q      <= samp_fmt_s;
                           miss_cnt_q <= 8'd0;
                           chg_q      <= 1'b1;
                        end else begin
                           stable_cnt_q <= stable_cnt_q + 8'd1;
                        end
                     end else begin
                        cand_w_q     <= samp_w_s;
                        cand_h_q     <= samp_h_s;
                        stable_cnt_q <= 8'd1;
                     end
                  end
                  // While locked the candidate holds the locked format, so
                  // match means "same as the locked format".
                  ST_LOCKED: begin
                     if (hit_s) begin
                        miss_cnt_q <= 8'd0;
                     end else begin
                        state_q    <= ST_HOLD;
                        miss_cnt_q <= 8'd1;
                     end
                  end
                  ST_HOLD: begin
                     if (hit_s) begin
                        state_q    <= ST_LOCKED;
                        miss_cnt_q <= 8'd0;
                     end else begin
                        miss_cnt_q <= miss_cnt_q + 8'd1;
                     end
                  end
                  default: begin
                     state_q <= ST_NO_SIGNAL;
                  end
               endcase
            end
         end
      end
   end

   assign o_state      = state_q;
   assign o_locked     = locked_q;
   assign o_width      = width_q;
   assign o_height     = height_q;
   assign o_fmt_code   = fmt_q;
   assign o_fps        = fps_q;
   assign o_fmt_change = chg_q;

endmodule
